verdict_collector: RTL and testbench

Downstream stage of the generated RTLola monitor `topEntity`. It watches the monitor's output streams and their activation flags, and timestamps every cycle in which at least one stream fires. Each such cycle becomes one record, buffered in a FIFO and handed to the host/trace interface over a valid/ready handshake. It decouples the monitor's one-cycle output pulses from a consumer that may stall.

---
 rtl/verdict_pkg.sv | 33 +++
 rtl/verdict_collector_sync_fifo.sv | 63 ++++++
 rtl/verdict_collector.sv | 109 ++++++++++
 tb/tb_verdict_collector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/verdict_pkg.sv
// Shared types and widths for the verdict collector: stream count, value width
// and the record layout handed to the host/trace side.
package verdict_pkg;

    localparam int VAL_W     = 64;
    localparam int N_STREAMS = 2;
    localparam int DROP_W    = 16;
    localparam int TS_W_DEF  = 64;

    // Everything in a record except the timestamp, whose width is a top-level parameter.
    typedef struct packed {
        logic [N_STREAMS-1:0] mask;
        logic [VAL_W-1:0]     val_0;
        logic [VAL_W-1:0]     val_1;
    } payload_t;

    localparam int PAY_W = $bits(payload_t);

    // Full record at the default timestamp width, for host-side consumers.
    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [N_STREAMS-1:0] mask;
        logic [VAL_W-1:0]     val_0;
        logic [VAL_W-1:0]     val_1;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    function automatic int rec_width(input int ts_w);
        return ts_w + PAY_W;
    endfunction

endpackage

// File: rtl/verdict_collector_sync_fifo.sv
// First-word fall-through FIFO with occupancy count; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      fill_reg;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (fill_reg != '0);
    assign full       = (fill_reg == FULL_CNT);
    assign do_pop     = pop && head_valid;
    assign do_push    = push && (!full || do_pop);

    // When full, wr_ptr == rd_ptr; the old head is read out before the edge overwrites it.
    assign head_data  = head_valid ? mem[rd_ptr_reg] : '0;
    assign fill       = fill_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill_reg <= fill_reg + (AW+1)'(1);
                2'b01:   fill_reg <= fill_reg - (AW+1)'(1);
                default: fill_reg <= fill_reg;
            endcase
        end
    end

endmodule

// File: rtl/verdict_collector.sv
// Timestamps every cycle in which a monitor stream fires, queues the records and
// presents them over valid/ready, counting records lost when the queue is full.
module verdict_collector
    import verdict_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [VAL_W-1:0]   output_0,
    input  logic                      output_0_aktv,
    input  logic signed [VAL_W-1:0]   output_1,
    input  logic                      output_1_aktv,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic [TS_W-1:0]           rec_ts,
    output logic [N_STREAMS-1:0]      rec_mask,
    output logic [VAL_W-1:0]          rec_val_0,
    output logic [VAL_W-1:0]          rec_val_1,
    output logic [$clog2(DEPTH):0]    fill,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_cnt
);

    localparam int W = TS_W + PAY_W;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [TS_W-1:0]      ts_reg;
    logic                 overflow_reg;
    logic [DROP_W-1:0]    drop_cnt_reg;

    logic [N_STREAMS-1:0] aktv;
    logic [VAL_W-1:0]     raw_val [N_STREAMS];
    logic [VAL_W-1:0]     cap_val [N_STREAMS];
    payload_t             cap_payload;
    payload_t             head_payload;
    logic [W-1:0]         push_data;
    logic [W-1:0]         head_data;
    logic                 capture;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 fifo_full;
    logic                 head_valid;

    assign aktv       = {output_1_aktv, output_0_aktv};
    assign raw_val[0] = output_0;
    assign raw_val[1] = output_1;

    // Values of inactive streams are forced to zero so records never carry stale data.
    generate
        for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_stream
            assign cap_val[gi] = aktv[gi] ? raw_val[gi] : '0;
        end
    endgenerate

    assign cap_payload = '{mask: aktv, val_0: cap_val[0], val_1: cap_val[1]};
    assign push_data   = {ts_reg, cap_payload};

    assign capture = en && (aktv != '0);
    assign pop     = en && head_valid && rec_ready;
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .full       (fifo_full),
        .fill       (fill)
    );

    assign head_payload = head_data[PAY_W-1:0];
    assign rec_valid    = head_valid;
    assign rec_ts       = head_data[W-1:PAY_W];
    assign rec_mask     = head_payload.mask;
    assign rec_val_0    = head_payload.val_0;
    assign rec_val_1    = head_payload.val_1;
    assign overflow     = overflow_reg;
    assign drop_cnt     = drop_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_reg       <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (en) begin
                ts_reg <= ts_reg + TS_W'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != DROP_MAX) begin
                    drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_verdict_collector.sv
// Directed plus randomized bench for verdict_collector against a queue-based reference.
module tb_verdict_collector;

    localparam int DEPTH = 8;
    localparam int TS_W  = 64;

    logic               clk;
    logic               rst;
    logic               en;
    logic signed [63:0] output_0;
    logic               output_0_aktv;
    logic signed [63:0] output_1;
    logic               output_1_aktv;
    logic               rec_valid;
    logic               rec_ready;
    logic [TS_W-1:0]    rec_ts;
    logic [1:0]         rec_mask;
    logic [63:0]        rec_val_0;
    logic [63:0]        rec_val_1;
    logic [3:0]         fill;
    logic               overflow;
    logic [15:0]        drop_cnt;

    verdict_collector #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .output_0      (output_0),
        .output_0_aktv (output_0_aktv),
        .output_1      (output_1),
        .output_1_aktv (output_1_aktv),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_ts        (rec_ts),
        .rec_mask      (rec_mask),
        .rec_val_0     (rec_val_0),
        .rec_val_1     (rec_val_1),
        .fill          (fill),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint unsigned ts;
        logic [1:0]      mask;
        logic [63:0]     v0;
        logic [63:0]     v1;
    } mrec_t;

    mrec_t           q[$];
    longint unsigned m_ts;
    bit              m_ovf;
    int              m_drop;
    int              n_cmp;
    int              n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts   = 0;
        m_ovf  = 0;
        m_drop = 0;
    endtask

    // Reference behaviour of one clock edge, from the record/push/pop rules.
    task automatic model_edge();
        bit    do_pop;
        mrec_t r;
        do_pop = en && (q.size() > 0) && rec_ready;
        if (do_pop) void'(q.pop_front());
        if (en && (output_0_aktv || output_1_aktv)) begin
            r.ts   = m_ts;
            r.mask = {output_1_aktv, output_0_aktv};
            r.v0   = output_0_aktv ? output_0 : 64'd0;
            r.v1   = output_1_aktv ? output_1 : 64'd0;
            if (q.size() < DEPTH) q.push_back(r);
            else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
        if (en) m_ts++;
    endtask

    task automatic check_all();
        check("rec_valid", 64'(rec_valid), 64'(q.size() != 0));
        check("fill", 64'(fill), 64'(q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (q.size() != 0) begin
            check("rec_ts", rec_ts, q[0].ts);
            check("rec_mask", 64'(rec_mask), 64'(q[0].mask));
            check("rec_val_0", rec_val_0, q[0].v0);
            check("rec_val_1", rec_val_1, q[0].v1);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_aktv(input bit a0, input bit a1, input logic [63:0] v0, input logic [63:0] v1);
        output_0_aktv = a0;
        output_1_aktv = a1;
        output_0      = v0;
        output_1      = v1;
    endtask

    longint unsigned t0;
    longint unsigned saved_ts;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        en = 1'b0;
        rec_ready = 1'b0;
        set_aktv(0, 0, 64'd0, 64'd0);
        model_reset();

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valid", 64'(rec_valid), 64'd0);
        check("reset_fill", 64'(fill), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_drop", 64'(drop_cnt), 64'd0);
        check("reset_ts", rec_ts, 64'd0);
        check("reset_mask", 64'(rec_mask), 64'd0);
        check("reset_val0", rec_val_0, 64'd0);
        check("reset_val1", rec_val_1, 64'd0);
        $display("reset released: fill=%0d valid=%0d", fill, rec_valid);

        // Single capture at ts=500
        en = 1'b1;
        while (m_ts != 500) step();
        set_aktv(1, 1, 64'd1, 64'd1);
        step();
        set_aktv(0, 0, 64'd0, 64'd0);
        check("single_valid", 64'(rec_valid), 64'd1);
        check("single_ts", rec_ts, 64'd500);
        check("single_mask", 64'(rec_mask), 64'd3);
        check("single_vals", {rec_val_0[31:0], rec_val_1[31:0]}, {32'd1, 32'd1});
        $display("single capture: ts=%0d mask=%b", rec_ts, rec_mask);
        rec_ready = 1'b1;
        step();
        check("single_pop_valid", 64'(rec_valid), 64'd0);
        check("single_pop_fill", 64'(fill), 64'd0);
        rec_ready = 1'b0;

        // Partial mask
        set_aktv(0, 1, 64'd9, -64'sd3);
        step();
        set_aktv(0, 0, 64'd0, 64'd0);
        check("partial_mask", 64'(rec_mask), 64'd2);
        check("partial_val0", rec_val_0, 64'd0);
        check("partial_val1", rec_val_1, 64'hFFFF_FFFF_FFFF_FFFD);
        $display("partial mask: mask=%b v0=%0d v1=%0d", rec_mask, rec_val_0, $signed(rec_val_1));
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;

        // Overflow: ten captures into eight slots
        t0 = m_ts;
        for (int i = 0; i < 10; i++) begin
            set_aktv(1, 0, 64'(i + 100), 64'd0);
            step();
        end
        set_aktv(0, 0, 64'd0, 64'd0);
        check("ovf_fill", 64'(fill), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        $display("overflow: fill=%0d overflow=%0d drop_cnt=%0d", fill, overflow, drop_cnt);
        rec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_ts", rec_ts, t0 + 64'(k));
            $display("drain: ts=%0d val0=%0d", rec_ts, rec_val_0);
            step();
        end
        check("drain_empty", 64'(rec_valid), 64'd0);
        rec_ready = 1'b0;

        // Full with a simultaneous pop
        t0 = m_ts;
        set_aktv(1, 1, 64'd7, 64'd8);
        repeat (8) step();
        check("full_fill", 64'(fill), 64'd8);
        rec_ready = 1'b1;
        step();
        set_aktv(0, 0, 64'd0, 64'd0);
        check("fullpop_fill", 64'(fill), 64'd8);
        check("fullpop_drop", 64'(drop_cnt), 64'd2);
        check("fullpop_head", rec_ts, t0 + 64'd1);
        $display("full+pop: fill=%0d head_ts=%0d", fill, rec_ts);
        repeat (8) step();
        rec_ready = 1'b0;

        // Enable low while streams fire
        saved_ts = m_ts;
        en = 1'b0;
        set_aktv(1, 1, 64'd5, 64'd6);
        repeat (5) step();
        check("en_low_fill", 64'(fill), 64'd0);
        check("en_low_valid", 64'(rec_valid), 64'd0);
        en = 1'b1;
        step();
        set_aktv(0, 0, 64'd0, 64'd0);
        check("en_low_ts", rec_ts, saved_ts);
        $display("enable low: resumed ts=%0d", rec_ts);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;

        // Asynchronous reset with three records stored
        set_aktv(1, 0, 64'd11, 64'd0);
        repeat (3) step();
        set_aktv(0, 0, 64'd0, 64'd0);
        check("prerst_fill", 64'(fill), 64'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_valid", 64'(rec_valid), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        $display("mid-run reset: fill=%0d valid=%0d", fill, rec_valid);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_aktv(1, 1, 64'd3, 64'd4);
        step();
        set_aktv(0, 0, 64'd0, 64'd0);
        check("post_rst_ts", rec_ts, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            rec_ready = ($urandom_range(0, 2) != 0);
            set_aktv(1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            step();
        end
        $display("random phase done: fill=%0d drop_cnt=%0d", fill, drop_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
